// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode constants,
// address-width helper and elaboration-time parameter legality checks.
package fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (longint unsigned p = 1; p < longint'(value); p = p << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Depth must be a power of two >= 2 and thresholds ordered 0 <= ae < af <= depth.
    function automatic bit fifo_params_ok(input int depth, input int af_level,
                                          input int ae_level);
        return (depth >= 2) && is_pow2(depth) &&
               (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: flop array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data_c
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, optional
// first-word-fall-through read and sticky overflow/underflow flags.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = clog2(FIFO_DEPTH),
    parameter int          AF_LEVEL   = int'(FIFO_DEPTH) - 2,
    parameter int          AE_LEVEL   = 2,
    parameter int unsigned FWFT       = FIFO_MODE_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

    // Reject illegal configurations during elaboration.
    if (!fifo_params_ok(int'(FIFO_DEPTH), AF_LEVEL, AE_LEVEL) ||
        (ADDR_WIDTH != clog2(FIFO_DEPTH)) ||
        (FWFT > FIFO_MODE_FWFT)) begin : g_bad_params
        $fatal(1, "sync_fifo_ctrl: illegal FIFO parameters");
    end

    logic [LW-1:0]         wptr;
    logic [LW-1:0]         rptr;
    logic [LW-1:0]         level_nxt;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Acceptance uses the registered flags, so a dropped request never
    // benefits from a simultaneous opposite operation.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    fifo_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk       (clk),
        .wr_en     (wr_accept && !rst),
        .wr_addr   (wptr[ADDR_WIDTH-1:0]),
        .wr_data   (wr_data),
        .rd_addr   (rptr[ADDR_WIDTH-1:0]),
        .rd_data_c (mem_rd_data)
    );

    always_comb begin
        level_nxt = level;
        if (wr_accept && !rd_accept) begin
            level_nxt = level + LW'(1);
        end else if (rd_accept && !wr_accept) begin
            level_nxt = level - LW'(1);
        end
    end

    // Pointers, level, flags derived from the next level, and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + LW'(1);
            end
            if (rd_accept) begin
                rptr <= rptr + LW'(1);
            end
            level        <= level_nxt;
            full         <= (level_nxt == DEPTH_L);
            empty        <= (level_nxt == '0);
            almost_full  <= (level_nxt >= AF_L);
            almost_empty <= (level_nxt <= AE_L);
            // A new error event takes priority over a clear in the same cycle.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is always presented; rd_en acknowledges it.
        assign rd_data  = mem_rd_data;
        assign rd_valid = !empty;
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_accept;
                if (rd_accept) begin
                    rd_data <= mem_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: standard and FWFT instances share stimulus and
// are compared against a queue-based model plus fixed vectors and sequences.
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    localparam logic [3:0] C_IDLE = 4'b0000;
    localparam logic [3:0] C_WR   = 4'b1000;
    localparam logic [3:0] C_RD   = 4'b0100;
    localparam logic [3:0] C_CLR  = 4'b0010;
    localparam logic [3:0] C_RST  = 4'b0001;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       clr_err;

    logic [7:0] rd_data_s, rd_data_f;
    logic       rd_valid_s, rd_valid_f;
    logic       full_s, full_f, empty_s, empty_f;
    logic       af_s, af_f, ae_s, ae_f;
    logic [4:0] level_s, level_f;
    logic       ovf_s, ovf_f, udf_s, udf_f;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
        .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
        .level(level_s), .overflow(ovf_s), .underflow(udf_s)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(rd_data_f), .rd_valid(rd_valid_f),
        .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
        .level(level_f), .overflow(ovf_f), .underflow(udf_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of stored words plus sticky flags and read register.
    logic [7:0] q[$];
    bit         m_ovf, m_udf, m_rv;
    logic [7:0] m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare both DUTs.
    task automatic do_cycle(input logic [3:0] ctl, input logic [7:0] d);
        bit was_full, was_empty;
        int sz;
        logic [6:0] mflg;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        {wr_en, rd_en, clr_err, rst} = ctl;
        wr_data = d;
        @(posedge clk);
        #1;
        if (ctl[0]) begin
            q.delete();
            m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = 8'h00;
        end else begin
            m_rv = ctl[2] && !was_empty;
            if (m_rv) m_rd = q.pop_front();
            if (ctl[3] && !was_full) q.push_back(d);
            m_ovf = (ctl[3] && was_full)  || (m_ovf && !ctl[1]);
            m_udf = (ctl[2] && was_empty) || (m_udf && !ctl[1]);
        end
        sz   = q.size();
        mflg = {sz == DEPTH, sz == 0, sz >= AF, sz <= AE, m_ovf, m_udf, m_rv};
        chk("std_level", 32'(level_s), 32'(sz));
        chk("std_flags{full,empty,af,ae,ovf,udf,rv}",
            32'({full_s, empty_s, af_s, ae_s, ovf_s, udf_s, rd_valid_s}), 32'(mflg));
        chk("std_rd_data", 32'(rd_data_s), 32'(m_rd));
        chk("fwft_level", 32'(level_f), 32'(sz));
        chk("fwft_flags{full,empty,af,ae,ovf,udf}",
            32'({full_f, empty_f, af_f, ae_f, ovf_f, udf_f}), 32'(mflg[6:1]));
        chk("fwft_rd_valid", 32'(rd_valid_f), 32'(sz != 0));
        if (sz != 0) chk("fwft_rd_data", 32'(rd_data_f), 32'(q[0]));
    endtask

    typedef struct packed {
        logic [3:0] ctl;   // {wr, rd, clr, rst}
        logic [7:0] wd;
        logic [4:0] lvl;
        logic [6:0] flg;   // {full, empty, af, ae, ovf, udf, rv}
        logic [7:0] rdat;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = {4'b0001, 8'h00, 5'd0, 7'b0101000, 8'h00};
        tbl[1]  = {4'b0000, 8'h00, 5'd0, 7'b0101000, 8'h00};
        tbl[2]  = {4'b0100, 8'h00, 5'd0, 7'b0101010, 8'h00};
        tbl[3]  = {4'b0010, 8'h00, 5'd0, 7'b0101000, 8'h00};
        tbl[4]  = {4'b1000, 8'h11, 5'd1, 7'b0001000, 8'h00};
        tbl[5]  = {4'b1000, 8'h22, 5'd2, 7'b0001000, 8'h00};
        tbl[6]  = {4'b1000, 8'h33, 5'd3, 7'b0000000, 8'h00};
        tbl[7]  = {4'b0100, 8'h00, 5'd2, 7'b0001001, 8'h11};
        tbl[8]  = {4'b0000, 8'h00, 5'd2, 7'b0001000, 8'h11};
        tbl[9]  = {4'b1100, 8'h44, 5'd2, 7'b0001001, 8'h22};
        tbl[10] = {4'b0100, 8'h00, 5'd1, 7'b0001001, 8'h33};
        tbl[11] = {4'b0110, 8'h00, 5'd0, 7'b0101001, 8'h44};
        tbl[12] = {4'b0100, 8'h00, 5'd0, 7'b0101010, 8'h44};
        tbl[13] = {4'b0110, 8'h00, 5'd0, 7'b0101010, 8'h44};
        tbl[14] = {4'b0010, 8'h00, 5'd0, 7'b0101000, 8'h44};
        tbl[15] = {4'b1100, 8'h55, 5'd1, 7'b0001010, 8'h44};
        tbl[16] = {4'b0110, 8'h00, 5'd0, 7'b0101001, 8'h55};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
        m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = 8'h00;

        // Fixed vectors: reset, underflow/clear, basic traffic, set-beats-clear.
        for (int i = 0; i < 17; i++) begin
            do_cycle(tbl[i].ctl, tbl[i].wd);
            chk($sformatf("vec%0d_level", i), 32'(level_s), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_flags", i),
                32'({full_s, empty_s, af_s, ae_s, ovf_s, udf_s, rd_valid_s}), 32'(tbl[i].flg));
            chk($sformatf("vec%0d_rd_data", i), 32'(rd_data_s), 32'(tbl[i].rdat));
        end

        // Fill to full, overflow, drain in order.
        for (int i = 0; i < 16; i++) begin
            do_cycle(C_WR, 8'(i));
            if (i == 12) chk("af_after_13_writes", 32'(af_s), 32'(0));
            if (i == 13) chk("af_after_14_writes", 32'(af_s), 32'(1));
            if (i == 14) chk("full_after_15_writes", 32'(full_s), 32'(0));
        end
        chk("full_after_16_writes", 32'(full_s), 32'(1));
        chk("level_after_16_writes", 32'(level_s), 32'(16));
        do_cycle(C_WR, 8'hEE);
        chk("overflow_on_17th_write", 32'(ovf_s), 32'(1));
        chk("level_after_17th_write", 32'(level_s), 32'(16));
        do_cycle(C_CLR, 8'h00);
        chk("overflow_cleared", 32'(ovf_s), 32'(0));
        for (int i = 0; i < 16; i++) begin
            do_cycle(C_RD, 8'h00);
            chk($sformatf("drain%0d_valid", i), 32'(rd_valid_s), 32'(1));
            chk($sformatf("drain%0d_data", i), 32'(rd_data_s), 32'(i));
        end
        chk("empty_after_drain", 32'(empty_s), 32'(1));

        // Pointer wrap with steady level 3.
        for (int i = 0; i < 3; i++) do_cycle(C_WR, 8'(8'h30 + i));
        for (int k = 0; k < 40; k++) begin
            do_cycle(C_WR | C_RD, 8'(8'h40 + k));
            chk($sformatf("wrap%0d_data", k), 32'(rd_data_s),
                (k < 3) ? 32'(8'h30 + k) : 32'(8'h40 + k - 3));
            chk($sformatf("wrap%0d_level", k), 32'(level_s), 32'(3));
            chk($sformatf("wrap%0d_flags", k),
                32'({full_s, empty_s, af_s, ae_s, ovf_s, udf_s, rd_valid_s}), 32'(7'b0000001));
        end
        for (int i = 0; i < 3; i++) do_cycle(C_RD, 8'h00);

        // Simultaneous write+read at full and at empty.
        for (int i = 0; i < 16; i++) do_cycle(C_WR, 8'(8'h80 + i));
        do_cycle(C_WR | C_RD, 8'hFF);
        chk("full_both_rd_data", 32'(rd_data_s), 32'(8'h80));
        chk("full_both_level", 32'(level_s), 32'(15));
        chk("full_both_overflow", 32'(ovf_s), 32'(1));
        do_cycle(C_CLR, 8'h00);
        for (int i = 0; i < 15; i++) do_cycle(C_RD, 8'h00);
        chk("last_of_full_drain", 32'(rd_data_s), 32'(8'h8F));
        do_cycle(C_WR | C_RD, 8'h66);
        chk("empty_both_level", 32'(level_s), 32'(1));
        chk("empty_both_underflow", 32'(udf_s), 32'(1));
        chk("empty_both_no_valid", 32'(rd_valid_s), 32'(0));
        do_cycle(C_RD | C_CLR, 8'h00);
        chk("empty_both_word", 32'(rd_data_s), 32'(8'h66));

        // FWFT: word falls through one cycle after the write.
        do_cycle(C_WR, 8'hA5);
        chk("fwft_fallthrough_data", 32'(rd_data_f), 32'(8'hA5));
        chk("fwft_fallthrough_valid", 32'(rd_valid_f), 32'(1));
        do_cycle(C_RD, 8'h00);
        chk("fwft_ack_empty", 32'(empty_f), 32'(1));
        chk("fwft_ack_valid", 32'(rd_valid_f), 32'(0));

        // Reset mid-operation with an accepted read in the same cycle.
        for (int i = 0; i < 7; i++) do_cycle(C_WR, 8'(8'h70 + i));
        chk("pre_reset_level", 32'(level_s), 32'(7));
        do_cycle(C_RST | C_RD, 8'h00);
        chk("reset_rd_valid", 32'(rd_valid_s), 32'(0));
        chk("reset_level", 32'(level_s), 32'(0));
        chk("reset_empty", 32'(empty_s), 32'(1));
        do_cycle(C_WR, 8'h5A);
        chk("post_reset_fwft_data", 32'(rd_data_f), 32'(8'h5A));
        do_cycle(C_RD, 8'h00);
        chk("post_reset_rd_data", 32'(rd_data_s), 32'(8'h5A));

        // Randomised traffic in write-heavy and read-heavy phases.
        for (int p = 0; p < 6; p++) begin
            for (int n = 0; n < 100; n++) begin
                logic [3:0] ctl;
                ctl[3] = (p % 2 == 0) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
                ctl[2] = (p % 2 == 0) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
                ctl[1] = ($urandom_range(15, 0) == 0);
                ctl[0] = ($urandom_range(127, 0) == 0);
                do_cycle(ctl, 8'($urandom));
            end
        end

        do_cycle(C_IDLE, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
